// File: rtl/nn_pkg.sv
// Shared types and defaults for the digit-classifier inference controller.
// Imported by the interface, the controller top and the stage watchdog.
package nn_pkg;

   localparam int DIGIT_W_DEF        = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int MAX_LAYERS         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN_LAYER,
      ST_RUN_MAX,
      ST_RESULT,
      ST_ERROR
   } nn_state_t;

   // Counter/index width able to hold 0..n-1; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nn_inference_ctrl_if.sv
// Bundle of the controller's host, datapath and result handshake signals.
// The master side is the controller; the slave side is the datapath/host.
interface nn_inference_ctrl_if
   import nn_pkg::*;
#(
   parameter int NUM_LAYERS = 2,
   parameter int DIGIT_W    = DIGIT_W_DEF
);

   logic                  start;
   logic                  busy;
   logic                  dp_clr;
   logic [NUM_LAYERS-1:0] layer_en;
   logic [NUM_LAYERS-1:0] layer_done;
   logic                  max_en;
   logic                  max_done;
   logic [DIGIT_W-1:0]    max_digit;
   logic                  result_valid;
   logic                  result_ready;
   logic [DIGIT_W-1:0]    result_digit;
   logic                  error;
   logic [15:0]           infer_cnt;

   modport master (
      input  start, layer_done, max_done, max_digit, result_ready,
      output busy, dp_clr, layer_en, max_en, result_valid, result_digit,
             error, infer_cnt
   );

   modport slave (
      output start, layer_done, max_done, max_digit, result_ready,
      input  busy, dp_clr, layer_en, max_en, result_valid, result_digit,
             error, infer_cnt
   );

endinterface

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter that flags a stage which has run for TIMEOUT_CYCLES
// cycles; the controller clears it whenever a new stage begins.
module stage_watchdog
   import nn_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int CW = idx_width(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   // Saturates at the terminal value so a stalled controller cannot wrap it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/nn_inference_ctrl.sv
// Sequences clear, the dense layers and the argmax stage for one inference,
// then presents the classified digit on a valid/ready result handshake.
module nn_inference_ctrl
   import nn_pkg::*;
#(
   parameter int NUM_LAYERS     = 2,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int DIGIT_W        = DIGIT_W_DEF
) (
   input logic                 clk,
   input logic                 reset,
   nn_inference_ctrl_if.master bus
);

   localparam int LIDX_W = idx_width(NUM_LAYERS);

   nn_state_t             state_q, state_d;
   logic [LIDX_W-1:0]     layer_idx_q, layer_idx_d;
   logic [DIGIT_W-1:0]    result_digit_q;
   logic [15:0]           infer_cnt_q;
   logic                  wd_clear;
   logic                  wd_count;
   logic                  wd_expired;
   logic                  capture_digit;
   logic                  count_inference;
   logic [NUM_LAYERS-1:0] layer_en_d;

   stage_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .count   (wd_count),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The watchdog is held clear outside the run stages and on the cycle a
   // stage finishes, so every stage starts counting from zero.
   always_comb begin
      state_d         = state_q;
      layer_idx_d     = layer_idx_q;
      wd_clear        = 1'b1;
      wd_count        = 1'b0;
      capture_digit   = 1'b0;
      count_inference = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            layer_idx_d = '0;
            state_d     = ST_RUN_LAYER;
         end
         ST_RUN_LAYER: begin
            wd_clear = 1'b0;
            wd_count = 1'b1;
            if (bus.layer_done[layer_idx_q]) begin
               wd_clear = 1'b1;
               if (layer_idx_q == LIDX_W'(NUM_LAYERS - 1)) begin
                  state_d = ST_RUN_MAX;
               end else begin
                  layer_idx_d = layer_idx_q + LIDX_W'(1);
               end
            end else if (wd_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_RUN_MAX: begin
            wd_clear = 1'b0;
            wd_count = 1'b1;
            if (bus.max_done) begin
               wd_clear      = 1'b1;
               capture_digit = 1'b1;
               state_d       = ST_RESULT;
            end else if (wd_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_RESULT: begin
            if (bus.result_ready) begin
               count_inference = 1'b1;
               state_d         = ST_IDLE;
            end
         end
         ST_ERROR: begin
            if (bus.start) state_d = ST_CLEAR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         layer_idx_q    <= '0;
         result_digit_q <= '0;
         infer_cnt_q    <= '0;
      end else begin
         layer_idx_q <= layer_idx_d;
         if (capture_digit) result_digit_q <= bus.max_digit;
         if (count_inference) infer_cnt_q <= infer_cnt_q + 16'd1;
      end
   end

   always_comb begin
      layer_en_d = '0;
      if (state_q == ST_RUN_LAYER) layer_en_d[layer_idx_q] = 1'b1;
   end

   assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_ERROR);
   assign bus.dp_clr       = (state_q == ST_CLEAR);
   assign bus.layer_en     = layer_en_d;
   assign bus.max_en       = (state_q == ST_RUN_MAX);
   assign bus.result_valid = (state_q == ST_RESULT);
   assign bus.error        = (state_q == ST_ERROR);
   assign bus.result_digit = result_digit_q;
   assign bus.infer_cnt    = infer_cnt_q;

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Directed self-checking bench for nn_inference_ctrl with two layers and a
// short 16-cycle stage timeout; expected values are worked out by hand.
module tb_nn_inference_ctrl;
   import nn_pkg::*;

   localparam int NL = 2;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic reset;

   int compared   = 0;
   int mismatched = 0;
   int dp_clr_pulses = 0;
   int enable_violations = 0;
   logic [15:0] exp_cnt = 16'd0;

   nn_inference_ctrl_if #(.NUM_LAYERS(NL), .DIGIT_W(DW)) bus ();

   nn_inference_ctrl #(
      .NUM_LAYERS     (NL),
      .TIMEOUT_CYCLES (16),
      .DIGIT_W        (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Counts clear pulses and flags any cycle with more than one stage enabled.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (bus.dp_clr === 1'b1) dp_clr_pulses++;
         if ($countones({bus.max_en, bus.layer_en}) > 1) enable_violations++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [2:0] stage_en();
      return {bus.max_en, bus.layer_en};
   endfunction

   task automatic wait_for_stage(input string tag, input logic [2:0] want);
      for (int i = 0; i < 64; i++) begin
         if (stage_en() === want) break;
         @(negedge clk);
      end
      checkOutput(tag, 32'(stage_en()), 32'(want));
   endtask

   // One full inference: dN are the cycles a stage runs before its done
   // arrives, hold is how long the host stalls the result handshake.
   task automatic applyStimulus(input string tag, input logic [3:0] digit,
                                input int d0, input int d1, input int dm,
                                input int hold);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput({tag, "_dp_clr"}, 32'(bus.dp_clr), 32'd1);
      checkOutput({tag, "_err_clr"}, 32'(bus.error), 32'd0);
      wait_for_stage({tag, "_l0_en"}, 3'b001);
      repeat (d0) @(negedge clk);
      bus.layer_done = 2'b01;
      @(negedge clk);
      bus.layer_done = 2'b00;
      checkOutput({tag, "_l1_en"}, 32'(stage_en()), 32'b010);
      repeat (d1) @(negedge clk);
      bus.layer_done = 2'b10;
      @(negedge clk);
      bus.layer_done = 2'b00;
      checkOutput({tag, "_max_en"}, 32'(stage_en()), 32'b100);
      repeat (dm) @(negedge clk);
      bus.max_digit = digit;
      bus.max_done  = 1'b1;
      @(negedge clk);
      bus.max_done  = 1'b0;
      bus.max_digit = 4'd0;
      checkOutput({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
      checkOutput({tag, "_digit"}, 32'(bus.result_digit), 32'(digit));
      checkOutput({tag, "_res_en"}, 32'(stage_en()), 32'd0);
      for (int i = 0; i < hold; i++) begin
         bus.start = ((i % 7) == 3);
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
         checkOutput({tag, "_hold_digit"}, 32'(bus.result_digit), 32'(digit));
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      checkOutput({tag, "_cnt"}, 32'(bus.infer_cnt), 32'(exp_cnt));
      checkOutput({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_idle_valid"}, 32'(bus.result_valid), 32'd0);
      checkOutput({tag, "_digit_held"}, 32'(bus.result_digit), 32'(digit));
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_dp_clr"}, 32'(bus.dp_clr), 32'd0);
      checkOutput({tag, "_enables"}, 32'(stage_en()), 32'd0);
      checkOutput({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
      checkOutput({tag, "_error"}, 32'(bus.error), 32'd0);
      checkOutput({tag, "_digit"}, 32'(bus.result_digit), 32'd0);
      checkOutput({tag, "_cnt"}, 32'(bus.infer_cnt), 32'd0);
   endtask

   initial begin
      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.layer_done   = '0;
      bus.max_done     = 1'b0;
      bus.max_digit    = '0;
      bus.result_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);

      // Nominal run with a long result stall and ignored start pulses.
      dp_clr_pulses = 0;
      applyStimulus("basic", 4'd7, 4, 6, 9, 20);
      checkOutput("basic_one_clr", 32'(dp_clr_pulses), 32'd1);

      // Foreign done bit ignored, done on the last watchdog cycle, then a hang.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("to_dp_clr", 32'(bus.dp_clr), 32'd1);
      wait_for_stage("to_l0_en", 3'b001);
      bus.layer_done = 2'b10;
      repeat (14) @(negedge clk);
      checkOutput("ignore_other_done", 32'(stage_en()), 32'b001);
      @(negedge clk);
      bus.layer_done = 2'b01;
      @(negedge clk);
      bus.layer_done = 2'b00;
      checkOutput("last_cycle_adv", 32'(stage_en()), 32'b010);
      checkOutput("last_cycle_noerr", 32'(bus.error), 32'd0);
      repeat (15) @(negedge clk);
      checkOutput("pre_timeout", 32'({bus.error, stage_en()}), 32'b0010);
      @(negedge clk);
      checkOutput("timeout_err", 32'(bus.error), 32'd1);
      checkOutput("timeout_busy", 32'(bus.busy), 32'd0);
      checkOutput("timeout_en", 32'(stage_en()), 32'd0);
      applyStimulus("restart", 4'd5, 2, 3, 4, 0);

      // Reset while the argmax stage is running.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_for_stage("rst_l0_en", 3'b001);
      bus.layer_done = 2'b01;
      @(negedge clk);
      bus.layer_done = 2'b10;
      @(negedge clk);
      bus.layer_done = 2'b00;
      checkOutput("rst_max_en", 32'(stage_en()), 32'b100);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("midrst");
      reset = 1'b0;
      exp_cnt = 16'd0;
      applyStimulus("clean", 4'd9, 1, 0, 2, 0);

      // Counter wrap from the all-ones value.
      force dut.infer_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.infer_cnt_q;
      #1;
      checkOutput("preload_cnt", 32'(bus.infer_cnt), 32'hFFFF);
      exp_cnt = 16'hFFFF;
      applyStimulus("wrap", 4'd3, 0, 0, 0, 0);

      checkOutput("enables_onehot", 32'(enable_violations), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
